// File: rtl/cdma_x_wr_arb.sv
// Round-robin command arbiter sharing one write DMA engine among N_REQ requesters.
// Steers each requester's write stream in command order and returns per-request completions.
module cdma_x_wr_arb #(
  parameter int N_REQ       = 4,
  parameter int ADDR_BITS   = 64,
  parameter int LEN_BITS    = 28,
  parameter int DATA_BITS   = 512,
  parameter int CHUNK_BITS  = 22,
  parameter int OUTSTANDING = 8
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ*ADDR_BITS-1:0]   req_paddr,
  input  logic [N_REQ*LEN_BITS-1:0]    req_len,
  output logic [N_REQ-1:0]             req_done,
  input  logic [N_REQ-1:0]             s_axis_tvalid,
  output logic [N_REQ-1:0]             s_axis_tready,
  input  logic [N_REQ*DATA_BITS-1:0]   s_axis_tdata,
  input  logic [N_REQ*DATA_BITS/8-1:0] s_axis_tkeep,
  input  logic [N_REQ-1:0]             s_axis_tlast,
  output logic                         dma_valid,
  input  logic                         dma_ready,
  output logic [ADDR_BITS-1:0]         dma_paddr,
  output logic [LEN_BITS-1:0]          dma_len,
  input  logic                         dma_done,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [DATA_BITS-1:0]         m_axis_tdata,
  output logic [DATA_BITS/8-1:0]       m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         err_zero_len,
  output logic                         err_spurious_done
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = $clog2(OUTSTANDING) + 1;
  localparam int AW = PW - 1;
  localparam int CW = LEN_BITS - CHUNK_BITS + 1;
  localparam int KW = DATA_BITS / 8;
  localparam logic [LEN_BITS:0] RND = (LEN_BITS+1)'((1 << CHUNK_BITS) - 1);

  typedef enum logic {ST_IDLE, ST_ISSUE} st_t;
  st_t st, st_nxt;

  logic [IW-1:0]        rr, grant, sel, idx, dsel;
  logic                 found, arb_ok, latch, drop, push, data_pop, full, data_ne, done_ne;
  logic [LEN_BITS-1:0]  sel_len, cmd_len;
  logic [ADDR_BITS-1:0] cmd_paddr;
  logic [CW-1:0]        sel_chunks, cmd_chunks, done_cnt;
  logic [PW-1:0]        wr, data_rd, done_rd;
  logic [IW-1:0]        id_mem  [OUTSTANDING];
  logic [CW-1:0]        chk_mem [OUTSTANDING];
  int                   j;

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] g);
    return (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  // first valid requester at or after the RR pointer, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(rr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IW'(j);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign sel_len    = req_len[sel*LEN_BITS +: LEN_BITS];
  assign sel_chunks = CW'(({1'b0, sel_len} + RND) >> CHUNK_BITS);

  assign full    = (wr[PW-1] != done_rd[PW-1]) && (wr[AW-1:0] == done_rd[AW-1:0]);
  assign data_ne = data_rd != wr;
  assign done_ne = done_rd != wr;
  assign arb_ok  = (st == ST_IDLE) && aresetn && !full && found;
  assign drop    = arb_ok && (sel_len == '0);
  assign latch   = arb_ok && (sel_len != '0);
  assign push    = (st == ST_ISSUE) && dma_ready;

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE:  if (latch) st_nxt = ST_ISSUE;
      ST_ISSUE: if (dma_ready) st_nxt = ST_IDLE;
      default:  st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) st <= ST_IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    req_ready = '0;
    if (push) req_ready[grant] = 1'b1;
    if (drop) req_ready[sel]   = 1'b1;
  end

  assign dma_valid = (st == ST_ISSUE);
  assign dma_paddr = cmd_paddr;
  assign dma_len   = cmd_len;

  always_ff @(posedge aclk) begin
    if (push) begin
      id_mem[wr[AW-1:0]]  <= grant;
      chk_mem[wr[AW-1:0]] <= cmd_chunks;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr <= '0; grant <= '0;
      cmd_paddr <= '0; cmd_len <= '0; cmd_chunks <= '0;
      wr <= '0; data_rd <= '0; done_rd <= '0; done_cnt <= '0;
      req_done <= '0; err_zero_len <= 1'b0; err_spurious_done <= 1'b0;
    end else begin
      req_done <= '0;
      if (latch) begin
        grant      <= sel;
        cmd_paddr  <= req_paddr[sel*ADDR_BITS +: ADDR_BITS];
        cmd_len    <= sel_len;
        cmd_chunks <= sel_chunks;
      end
      if (drop) begin
        rr           <= rr_next(sel);
        err_zero_len <= 1'b1;
      end
      if (push) begin
        wr <= wr + 1'b1;
        rr <= rr_next(grant);
      end
      if (data_pop) data_rd <= data_rd + 1'b1;
      // the engine may finish a chunk before the data entry retires, so count independently
      if (dma_done) begin
        if (!done_ne) err_spurious_done <= 1'b1;
        else if (done_cnt + 1'b1 == chk_mem[done_rd[AW-1:0]]) begin
          req_done[id_mem[done_rd[AW-1:0]]] <= 1'b1;
          done_rd  <= done_rd + 1'b1;
          done_cnt <= '0;
        end else done_cnt <= done_cnt + 1'b1;
      end
    end
  end

  assign dsel = id_mem[data_rd[AW-1:0]];

  always_comb begin
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    if (data_ne) begin
      m_axis_tvalid       = s_axis_tvalid[dsel];
      m_axis_tdata        = s_axis_tdata[dsel*DATA_BITS +: DATA_BITS];
      m_axis_tkeep        = s_axis_tkeep[dsel*KW +: KW];
      m_axis_tlast        = s_axis_tlast[dsel];
      s_axis_tready[dsel] = m_axis_tready;
    end
  end

  assign data_pop = m_axis_tvalid && m_axis_tready && m_axis_tlast;
endmodule
